// File: rtl/instr_encoder_loader.sv
// Purpose : encodes symbolic instruction requests into 32-bit MIPS words and
//           writes them to sequential instruction-memory addresses.
// Latency : 1 cycle from an accepted request to the matching imem_we pulse.
// Backpr. : req_ready is high only in LOAD while no final or full write is
//           pending. One request is accepted per cycle at most.
// Ports   : clk/rst_n          clock, asynchronous active-low reset
//           start              begin a session (honoured in IDLE/DONE)
//           req_*              valid/ready request: kind, rs/rt/rd, shamt,
//                              imm, target, last
//           imem_we/addr/wdata registered write port to instruction memory
//           busy/done          state == LOAD / state == DONE
//           err_illegal        sticky: an illegal kind was accepted
//           err_full           sticky: the address space was exhausted
module instr_encoder_loader #(
  parameter int                ADDR_W    = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_kind,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_shamt,
  input  logic [15:0]       req_imm,
  input  logic [25:0]       req_target,
  input  logic              req_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err_illegal,
  output logic              err_full
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] K_ADD   = 4'd0;
  localparam logic [3:0] K_SUB   = 4'd1;
  localparam logic [3:0] K_AND   = 4'd2;
  localparam logic [3:0] K_OR    = 4'd3;
  localparam logic [3:0] K_SLT   = 4'd4;
  localparam logic [3:0] K_XOR   = 4'd5;
  localparam logic [3:0] K_SLL   = 4'd6;
  localparam logic [3:0] K_ADDIU = 4'd7;
  localparam logic [3:0] K_ADDI  = 4'd8;
  localparam logic [3:0] K_ORI   = 4'd9;
  localparam logic [3:0] K_LUI   = 4'd10;
  localparam logic [3:0] K_LW    = 4'd11;
  localparam logic [3:0] K_SW    = 4'd12;
  localparam logic [3:0] K_BEQ   = 4'd13;
  localparam logic [3:0] K_J     = 4'd14;

  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                pend_last_q, pend_last_d;
  logic                pend_full_q, pend_full_d;
  logic                err_ill_q, err_ill_d;
  logic                err_full_q, err_full_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;

  logic                enc_legal;
  logic [31:0]         enc_word;
  logic                accept;

  // Encoder: the op/func values match what the control decoder expects.
  // SLL ignores rs, LUI ignores rs, other R-type ignore shamt.
  always_comb begin
    enc_legal = 1'b1;
    enc_word  = '0;
    case (req_kind)
      K_ADD:   enc_word = {6'b000000, req_rs, req_rt, req_rd, 5'd0, 6'b100000};
      K_SUB:   enc_word = {6'b000000, req_rs, req_rt, req_rd, 5'd0, 6'b100010};
      K_AND:   enc_word = {6'b000000, req_rs, req_rt, req_rd, 5'd0, 6'b100100};
      K_OR:    enc_word = {6'b000000, req_rs, req_rt, req_rd, 5'd0, 6'b100101};
      K_SLT:   enc_word = {6'b000000, req_rs, req_rt, req_rd, 5'd0, 6'b101010};
      K_XOR:   enc_word = {6'b000000, req_rs, req_rt, req_rd, 5'd0, 6'b100110};
      K_SLL:   enc_word = {6'b000000, 5'd0, req_rt, req_rd, req_shamt, 6'b000000};
      K_ADDIU: enc_word = {6'b001001, req_rs, req_rt, req_imm};
      K_ADDI:  enc_word = {6'b001000, req_rs, req_rt, req_imm};
      K_ORI:   enc_word = {6'b001101, req_rs, req_rt, req_imm};
      K_LUI:   enc_word = {6'b001111, 5'd0, req_rt, req_imm};
      K_LW:    enc_word = {6'b100011, req_rs, req_rt, req_imm};
      K_SW:    enc_word = {6'b101011, req_rs, req_rt, req_imm};
      K_BEQ:   enc_word = {6'b000100, req_rs, req_rt, req_imm};
      K_J:     enc_word = {6'b000010, req_target};
      default: enc_legal = 1'b0;
    endcase
  end

  // Once the final or the top-of-memory word is in flight, stop accepting
  // so nothing follows it.
  assign req_ready = (state_q == S_LOAD) && !pend_last_q && !pend_full_q;
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_last_d = pend_last_q;
    pend_full_d = pend_full_q;
    err_ill_d   = err_ill_q;
    err_full_d  = err_full_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_LOAD;
          cnt_d       = BASE_ADDR;
          pend_last_d = 1'b0;
          pend_full_d = 1'b0;
          err_ill_d   = 1'b0;
          err_full_d  = 1'b0;
        end
      end
      S_LOAD: begin
        if (pend_last_q || pend_full_q) begin
          // The closing write is on the port this cycle; finish after it.
          state_d     = S_DONE;
          pend_last_d = 1'b0;
          pend_full_d = 1'b0;
        end else if (accept) begin
          if (enc_legal) begin
            we_d    = 1'b1;
            addr_d  = cnt_q;
            wdata_d = enc_word;
            cnt_d   = cnt_q + 1'b1;
            if (req_last) begin
              pend_last_d = 1'b1;
            end else if (cnt_q == ADDR_MAX) begin
              pend_full_d = 1'b1;
              err_full_d  = 1'b1;
            end
          end else begin
            // Illegal kind is swallowed; nothing to write, so a final
            // illegal request ends the session straight away.
            err_ill_d = 1'b1;
            if (req_last) begin
              state_d = S_DONE;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= BASE_ADDR;
      pend_last_q <= 1'b0;
      pend_full_q <= 1'b0;
      err_ill_q   <= 1'b0;
      err_full_q  <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_last_q <= pend_last_d;
      pend_full_q <= pend_full_d;
      err_ill_q   <= err_ill_d;
      err_full_q  <= err_full_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

  assign imem_we     = we_q;
  assign imem_addr   = addr_q;
  assign imem_wdata  = wdata_q;
  assign busy        = (state_q == S_LOAD);
  assign done        = (state_q == S_DONE);
  assign err_illegal = err_ill_q;
  assign err_full    = err_full_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Purpose : scoreboard bench for instr_encoder_loader (default and 2-bit address).
// Latency : expected writes are queued at the accept edge, checked at negedge.
// Backpr. : requests are held until req_ready, bounded by a cycle budget.
module tb_instr_encoder_loader;

  localparam logic [3:0] K_ADD = 4'd0, K_SUB = 4'd1, K_OR = 4'd3, K_SLL = 4'd6,
                         K_ADDIU = 4'd7, K_LUI = 4'd10, K_LW = 4'd11, K_SW = 4'd12,
                         K_BEQ = 4'd13, K_J = 4'd14, K_ILL = 4'd15;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_a, start_b, vld_a, vld_b;
  logic        rdy_a, rdy_b;
  logic [3:0]  kind;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [25:0] tgt;
  logic        last;

  logic        we_a, busy_a, done_a, eill_a, efull_a;
  logic [9:0]  addr_a;
  logic [31:0] wdata_a;
  logic        we_b, busy_b, done_b, eill_b, efull_b;
  logic [1:0]  addr_b;
  logic [31:0] wdata_b;

  exp_t        q_a[$];
  exp_t        q_b[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          ea_a = 0;
  int          ea_b = 0;

  always #5 clk = ~clk;

  instr_encoder_loader #(.ADDR_W(10)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .req_valid(vld_a), .req_ready(rdy_a),
    .req_kind(kind), .req_rs(rs), .req_rt(rt), .req_rd(rd), .req_shamt(shamt),
    .req_imm(imm), .req_target(tgt), .req_last(last),
    .imem_we(we_a), .imem_addr(addr_a), .imem_wdata(wdata_a),
    .busy(busy_a), .done(done_a), .err_illegal(eill_a), .err_full(efull_a)
  );

  instr_encoder_loader #(.ADDR_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .req_valid(vld_b), .req_ready(rdy_b),
    .req_kind(kind), .req_rs(rs), .req_rt(rt), .req_rd(rd), .req_shamt(shamt),
    .req_imm(imm), .req_target(tgt), .req_last(last),
    .imem_we(we_b), .imem_addr(addr_b), .imem_wdata(wdata_b),
    .busy(busy_b), .done(done_b), .err_illegal(eill_b), .err_full(efull_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitors: every write must match the head of its scoreboard queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (we_a === 1'b1) begin
        n_checks++;
        if (q_a.size() == 0) begin
          n_fail++;
          $display("FAIL a_unexpected_write: got addr %h data %h expected no write", addr_a, wdata_a);
        end else begin
          e = q_a.pop_front();
          if (32'(addr_a) !== e.addr || wdata_a !== e.data) begin
            n_fail++;
            $display("FAIL a_write: got addr %h data %h expected addr %h data %h",
                     addr_a, wdata_a, e.addr, e.data);
          end
        end
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (we_b === 1'b1) begin
        n_checks++;
        if (q_b.size() == 0) begin
          n_fail++;
          $display("FAIL b_unexpected_write: got addr %h data %h expected no write", addr_b, wdata_b);
        end else begin
          e = q_b.pop_front();
          if (32'(addr_b) !== e.addr || wdata_b !== e.data) begin
            n_fail++;
            $display("FAIL b_write: got addr %h data %h expected addr %h data %h",
                     addr_b, wdata_b, e.addr, e.data);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input bit sel);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    step();
    start_a = 1'b0;
    start_b = 1'b0;
    if (sel) ea_b = 0; else ea_a = 0;
  endtask

  // Present one request and hold it until accepted; queue the expected write.
  task automatic send(input bit sel, input logic [3:0] k, input logic [4:0] f_rs,
                      input logic [4:0] f_rt, input logic [4:0] f_rd, input logic [4:0] f_sh,
                      input logic [15:0] f_imm, input logic [25:0] f_tgt, input bit f_last,
                      input bit legal, input logic [31:0] word);
    bit got;
    bit r;
    got = 1'b0;
    kind = k; rs = f_rs; rt = f_rt; rd = f_rd; shamt = f_sh;
    imm = f_imm; tgt = f_tgt; last = f_last;
    if (sel) vld_b = 1'b1; else vld_a = 1'b1;
    for (int i = 0; i < 50; i++) begin
      r = sel ? rdy_b : rdy_a;
      @(posedge clk);
      if (r) begin
        got = 1'b1;
        if (legal) begin
          if (sel) begin q_b.push_back('{addr: ea_b, data: word}); ea_b++; end
          else     begin q_a.push_back('{addr: ea_a, data: word}); ea_a++; end
        end
      end
      #1;
      if (got) break;
    end
    vld_a = 1'b0;
    vld_b = 1'b0;
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL handshake_timeout: got no accept in 50 cycles expected accept (kind %0d)", k);
    end
  endtask

  initial begin
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; vld_a = 1'b0; vld_b = 1'b0;
    kind = '0; rs = '0; rt = '0; rd = '0; shamt = '0; imm = '0; tgt = '0; last = 1'b0;
    repeat (3) step();
    chk("reset_we", 32'(we_a), 0);
    chk("reset_addr", 32'(addr_a), 0);
    chk("reset_wdata", wdata_a, 0);
    chk("reset_ready", 32'(rdy_a), 0);
    chk("reset_flags", {27'd0, busy_a, done_a, eill_a, efull_a, 1'b0}, 0);
    rst_n = 1'b1;
    step();

    // Session 1: ADDIU, back-to-back ADD, final J.
    do_start(0);
    chk("s1_busy", 32'(busy_a), 1);
    chk("s1_ready", 32'(rdy_a), 1);
    send(0, K_ADDIU, 5'd0, 5'd8, 5'd0, 5'd0, 16'h0005, 26'd0, 0, 1, 32'h2408_0005);
    send(0, K_ADD,   5'd8, 5'd9, 5'd10, 5'd0, 16'h0000, 26'd0, 0, 1, 32'h0109_5020);
    send(0, K_J,     5'd0, 5'd0, 5'd0, 5'd0, 16'h0000, 26'h0000010, 1, 1, 32'h0800_0010);
    chk("s1_ready_after_last", 32'(rdy_a), 0);
    step();
    chk("s1_done", 32'(done_a), 1);
    chk("s1_busy_end", 32'(busy_a), 0);
    chk("s1_no_illegal", 32'(eill_a), 0);
    step();
    chk("s1_done_holds", 32'(done_a), 1);
    chk("s1_wdata_holds", wdata_a, 32'h0800_0010);
    chk("s1_addr_holds", 32'(addr_a), 2);

    // Session 2: forced fields, illegal kinds, restart from DONE.
    do_start(0);
    chk("s2_done_cleared", 32'(done_a), 0);
    send(0, K_SLL,   5'd3, 5'd4, 5'd5, 5'd2, 16'h0000, 26'd0, 0, 1, 32'h0004_2880);
    send(0, K_ILL,   5'd1, 5'd1, 5'd1, 5'd1, 16'hFFFF, 26'd0, 0, 0, 32'h0);
    chk("s2_err_illegal", 32'(eill_a), 1);
    send(0, K_LUI,   5'd7, 5'd1, 5'd0, 5'd0, 16'h1234, 26'd0, 0, 1, 32'h3C01_1234);
    send(0, K_SUB,   5'd1, 5'd2, 5'd3, 5'd0, 16'h0000, 26'd0, 0, 1, 32'h0022_1822);
    send(0, K_OR,    5'd4, 5'd5, 5'd6, 5'd7, 16'h0000, 26'd0, 0, 1, 32'h0085_3025);
    send(0, K_LW,    5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 26'd0, 0, 1, 32'h8FA8_0004);
    send(0, K_SW,    5'd29, 5'd31, 5'd0, 5'd0, 16'hFFFC, 26'd0, 0, 1, 32'hAFBF_FFFC);
    send(0, K_BEQ,   5'd1, 5'd2, 5'd0, 5'd0, 16'h0003, 26'd0, 0, 1, 32'h1022_0003);
    send(0, K_ILL,   5'd0, 5'd0, 5'd0, 5'd0, 16'h0000, 26'd0, 1, 0, 32'h0);
    chk("s2_done_after_illegal_last", 32'(done_a), 1);
    chk("s2_err_illegal_sticky", 32'(eill_a), 1);
    chk("s2_no_full", 32'(efull_a), 0);

    // Session 3: start clears flags; reset with a request in flight.
    do_start(0);
    chk("s3_err_cleared", 32'(eill_a), 0);
    kind = K_ADD; rs = 5'd1; rt = 5'd2; rd = 5'd3; shamt = '0; last = 1'b0;
    vld_a = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_ready", 32'(rdy_a), 0);
    repeat (2) step();
    chk("rst_we", 32'(we_a), 0);
    chk("rst_addr", 32'(addr_a), 0);
    vld_a = 1'b0;
    rst_n = 1'b1;
    step();
    do_start(0);
    send(0, K_ADDIU, 5'd0, 5'd8, 5'd0, 5'd0, 16'h0005, 26'd0, 1, 1, 32'h2408_0005);
    step();
    chk("s3_done", 32'(done_a), 1);

    // Small address space: four writes fill it, the fifth is refused.
    do_start(1);
    send(1, K_ADDIU, 5'd0, 5'd1, 5'd0, 5'd0, 16'h0001, 26'd0, 0, 1, 32'h2401_0001);
    send(1, K_ADDIU, 5'd0, 5'd2, 5'd0, 5'd0, 16'h0002, 26'd0, 0, 1, 32'h2402_0002);
    send(1, K_ADDIU, 5'd0, 5'd3, 5'd0, 5'd0, 16'h0003, 26'd0, 0, 1, 32'h2403_0003);
    send(1, K_ADDIU, 5'd0, 5'd4, 5'd0, 5'd0, 16'h0004, 26'd0, 0, 1, 32'h2404_0004);
    kind = K_ADDIU; rt = 5'd5; imm = 16'h0005; last = 1'b0;
    vld_b = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("full_ready_low", 32'(rdy_b), 0);
      step();
    end
    vld_b = 1'b0;
    chk("full_err_full", 32'(efull_b), 1);
    chk("full_done", 32'(done_b), 1);
    chk("full_busy", 32'(busy_b), 0);

    repeat (3) step();
    chk("a_queue_drained", q_a.size(), 0);
    chk("b_queue_drained", q_b.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
